reg_file_p: RTL and testbench

Parametrised successor to the 8×8 microprocessor register file, sized by parameters instead of fixed widths. It provides two registered read ports, one write port and an asynchronous active-low reset that clears all contents. A per-register busy scoreboard lets the issue stage reserve a destination register and see pending writes on reads. It sits between decode (reads and reservations) and writeback (writes) in the lab datapath.

---
 rtl/reg_file_p.sv | 116 +++++++++++
 tb/tb_reg_file_p.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_p.sv
// reg_file_p - parametrised register file with a busy scoreboard.
//
// Two registered read ports, one write port and one reserve port. A
// reservation marks a destination busy; an effective write to that register
// stores the data and clears busy. Reads return the data and busy bit of the
// addressed register one cycle after the address is presented.
//
// Parameters:
//   DATA_W   register width
//   ADDR_W   address width, DEPTH = 2**ADDR_W
//   ZERO_REG 1: register 0 reads as zero and ignores writes/reservations
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   rd_addr_a/b              read addresses
//   rd_data_a/b, rd_busy_a/b registered read data and busy flags
//   wr_en, wr_addr, wr_data  write port
//   rsv_en, rsv_addr         reserve port
//   busy_vec                 unregistered view of all busy bits
//
// Build option: define REGF_BYPASS_EN to forward a same-edge write to the
// read ports; otherwise reads see pre-edge contents and busy.
module reg_file_p #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic [DATA_W-1:0]    rd_data_b,
  output logic                 rd_busy_a,
  output logic                 rd_busy_b,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic [(2**ADDR_W)-1:0] busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_eff;
  logic              rsv_eff;
  logic [DATA_W-1:0] data_a_nxt, data_b_nxt;
  logic              busy_a_nxt, busy_b_nxt;

  assign wr_eff  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
  assign rsv_eff = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Reservation is applied after the write clear so a same-address
  // write+reserve leaves the register busy for its new producer.
  always_comb begin
    busy_nxt = busy;
    if (wr_eff)  busy_nxt[wr_addr]  = 1'b0;
    if (rsv_eff) busy_nxt[rsv_addr] = 1'b1;
  end

  always_comb begin
    data_a_nxt = regs[rd_addr_a];
    busy_a_nxt = busy[rd_addr_a];
    data_b_nxt = regs[rd_addr_b];
    busy_b_nxt = busy[rd_addr_b];
`ifdef REGF_BYPASS_EN
    if (wr_eff && (rd_addr_a == wr_addr)) begin
      data_a_nxt = wr_data;
      busy_a_nxt = busy_nxt[rd_addr_a];
    end
    if (wr_eff && (rd_addr_b == wr_addr)) begin
      data_b_nxt = wr_data;
      busy_b_nxt = busy_nxt[rd_addr_b];
    end
`endif
    if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
      data_a_nxt = '0;
      busy_a_nxt = 1'b0;
    end
    if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
      data_b_nxt = '0;
      busy_b_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_eff) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_busy_a <= 1'b0;
      rd_busy_b <= 1'b0;
    end else begin
      busy      <= busy_nxt;
      rd_data_a <= data_a_nxt;
      rd_data_b <= data_b_nxt;
      rd_busy_a <= busy_a_nxt;
      rd_busy_b <= busy_b_nxt;
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_reg_file_p.sv
// Directed and random bench for reg_file_p. Builds with or without
// REGF_BYPASS_EN; expectations follow the selected setting.
module tb_reg_file_p;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, rsv_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0, rsv_en = 1'b0;
  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_busy_a, rd_busy_b;
  logic [7:0] busy_vec;

  logic [3:0]  p_rd_addr_a = '0, p_rd_addr_b = '0, p_wr_addr = '0, p_rsv_addr = '0;
  logic [15:0] p_wr_data = '0;
  logic        p_wr_en = 1'b0, p_rsv_en = 1'b0;
  logic [15:0] p_rd_data_a, p_rd_data_b;
  logic        p_rd_busy_a, p_rd_busy_b;
  logic [15:0] p_busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_regs [8];
  logic [7:0] m_busy;

  always #5 clk = ~clk;

  reg_file_p #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  reg_file_p #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(p_rd_addr_a), .rd_addr_b(p_rd_addr_b),
    .rd_data_a(p_rd_data_a), .rd_data_b(p_rd_data_b),
    .rd_busy_a(p_rd_busy_a), .rd_busy_b(p_rd_busy_b),
    .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .rsv_en(p_rsv_en), .rsv_addr(p_rsv_addr), .busy_vec(p_busy_vec)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predict read results from the model and the inputs now applied, clock
  // one edge, then compare every 8-bit DUT output against the prediction.
  task automatic tick();
    logic [7:0] nb, ea, eb;
    logic       ba, bb, we, re;
    we = wr_en  && (wr_addr  != 3'd0);
    re = rsv_en && (rsv_addr != 3'd0);
    nb = m_busy;
    if (we) nb[wr_addr]  = 1'b0;
    if (re) nb[rsv_addr] = 1'b1;
    ea = m_regs[rd_addr_a]; ba = m_busy[rd_addr_a];
    eb = m_regs[rd_addr_b]; bb = m_busy[rd_addr_b];
`ifdef REGF_BYPASS_EN
    if (we && wr_addr == rd_addr_a) begin ea = wr_data; ba = nb[rd_addr_a]; end
    if (we && wr_addr == rd_addr_b) begin eb = wr_data; bb = nb[rd_addr_b]; end
`endif
    if (rd_addr_a == 3'd0) begin ea = '0; ba = 1'b0; end
    if (rd_addr_b == 3'd0) begin eb = '0; bb = 1'b0; end
    if (we) m_regs[wr_addr] = wr_data;
    m_busy = nb;
    @(posedge clk); #1;
    check("rd_data_a", 32'(rd_data_a), 32'(ea));
    check("rd_data_b", 32'(rd_data_b), 32'(eb));
    check("rd_busy_a", 32'(rd_busy_a), 32'(ba));
    check("rd_busy_b", 32'(rd_busy_b), 32'(bb));
    check("busy_vec",  32'(busy_vec),  32'(m_busy));
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_busy = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_data_a", 32'(rd_data_a), 32'h0);
    check("reset_busy_vec", 32'(busy_vec), 32'h0);
    check("reset_p_busy_vec", 32'(p_busy_vec), 32'h0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Async reset mid-operation
    wr_en = 1; wr_addr = 3; wr_data = 8'hA5; rsv_en = 1; rsv_addr = 6; rd_addr_a = 3;
    tick();
    idle();
    tick();
    check("pre_rst_r3", 32'(rd_data_a), 32'hA5);
    check("pre_rst_busy", 32'(busy_vec), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data_a", 32'(rd_data_a), 32'h0);
    check("async_rst_data_b", 32'(rd_data_b), 32'h0);
    check("async_rst_busy_vec", 32'(busy_vec), 32'h0);
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_busy = '0;
    #2 rst_n = 1'b1;
    rd_addr_a = 3;
    tick();
    check("post_rst_r3", 32'(rd_data_a), 32'h0);

    // Write / read, zero register
    wr_en = 1; wr_addr = 5; wr_data = 8'h3C;
    tick();
    idle(); rd_addr_a = 5; rd_addr_b = 0;
    tick();
    check("r5", 32'(rd_data_a), 32'h3C);
    check("r0", 32'(rd_data_b), 32'h00);
    wr_en = 1; wr_addr = 0; wr_data = 8'hFF;
    tick();
    idle();
    tick();
    check("r0_after_wr", 32'(rd_data_b), 32'h00);

    // Scoreboard
    rsv_en = 1; rsv_addr = 2; rd_addr_a = 2;
    tick();
    check("rsv_r2_vec", 32'(busy_vec[2]), 32'h1);
    idle();
    tick();
    check("rsv_r2_rd_busy", 32'(rd_busy_a), 32'h1);
    wr_en = 1; wr_addr = 2; wr_data = 8'h11;
    tick();
    check("wr_r2_clear", 32'(busy_vec[2]), 32'h0);
    wr_en = 1; wr_addr = 2; wr_data = 8'h22; rsv_en = 1; rsv_addr = 2;
    tick();
    check("wr_rsv_r2_vec", 32'(busy_vec[2]), 32'h1);
    idle();
    tick();
    check("wr_rsv_r2_data", 32'(rd_data_a), 32'h22);
    check("wr_rsv_r2_busy", 32'(rd_busy_a), 32'h1);

    // Same-edge write/read
    wr_en = 1; wr_addr = 4; wr_data = 8'h10;
    tick();
    wr_en = 1; wr_addr = 4; wr_data = 8'h7E; rd_addr_a = 4; rd_addr_b = 4;
    tick();
`ifdef REGF_BYPASS_EN
    check("bypass_a", 32'(rd_data_a), 32'h7E);
    check("bypass_b", 32'(rd_data_b), 32'h7E);
`else
    check("nobypass_a", 32'(rd_data_a), 32'h10);
    check("nobypass_b", 32'(rd_data_b), 32'h10);
`endif
    idle();
    tick();
    check("r4_next_a", 32'(rd_data_a), 32'h7E);
    check("r4_next_b", 32'(rd_data_b), 32'h7E);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 3'($urandom_range(0, 7));
      wr_data   = 8'($urandom);
      rsv_en    = ($urandom_range(0, 3) == 0);
      rsv_addr  = 3'($urandom_range(0, 7));
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      tick();
    end
    idle();

    // Wide configuration, ordinary register 0
    p_wr_en = 1; p_wr_addr = 0; p_wr_data = 16'hBEEF;
    @(posedge clk); #1;
    p_wr_addr = 15; p_wr_data = 16'h1234;
    @(posedge clk); #1;
    p_wr_en = 0; p_rd_addr_a = 0; p_rd_addr_b = 15;
    p_rsv_en = 1; p_rsv_addr = 0;
    @(posedge clk); #1;
    check("p_r0", 32'(p_rd_data_a), 32'hBEEF);
    check("p_r15", 32'(p_rd_data_b), 32'h1234);
    p_rsv_addr = 15;
    @(posedge clk); #1;
    p_rsv_en = 0;
    check("p_busy_vec", 32'(p_busy_vec), 32'h8001);
    @(posedge clk); #1;
    check("p_rd_busy_a", 32'(p_rd_busy_a), 32'h1);
    check("p_rd_busy_b", 32'(p_rd_busy_b), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
